iformat_seq_ctrl: RTL and testbench

Multi-cycle sequencer that executes one uPower I-format instruction at a time over the single-port register file. It accepts an instruction via a valid/ready handshake, decodes rs/rt/imm, and reads rs through the file's registered read port. It then computes the ALU result with the immediate, writes it back to rt, and reports completion. It sits between the fetch/issue stage and the register file, and is the file's only master.

---
 rtl/iformat_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_iformat_seq_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iformat_seq_ctrl.sv
// Multi-cycle sequencer for uPower I-format ALU instructions over a single-port
// register file. Define IFMT_BYPASS_EN to forward the last written-back value.
module iformat_seq_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              illegal
);

  localparam logic [5:0] OP_ADDI = 6'b001110;
  localparam logic [5:0] OP_SUBI = 6'b001111;
  localparam logic [5:0] OP_ANDI = 6'b011100;
  localparam logic [5:0] OP_ORI  = 6'b011000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_EXEC,
    S_WB,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              accept;
  logic              legal_in;
  logic              bypass_hit;
  logic [ADDR_W-1:0] rs_in;

  logic [5:0]        opcode_q;
  logic [ADDR_W-1:0] rt_q;
  logic [15:0]       imm_q;
  logic              illegal_q;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;

  assign rs_in    = ADDR_W'(instr[25:21]);
  assign legal_in = instr[31:26] inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI};

`ifdef IFMT_BYPASS_EN
  logic [ADDR_W-1:0] last_rt;
  logic [DATA_W-1:0] last_val;
  logic              last_ok;

  // The write-back value is remembered so a dependent instruction can skip the read.
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_ok  <= 1'b0;
      last_rt  <= '0;
      last_val <= '0;
    end else if (state == S_WB) begin
      last_ok  <= 1'b1;
      last_rt  <= rt_q;
      last_val <= rf_wdata;
    end
  end

  assign bypass_hit = last_ok && (rs_in == last_rt);
`else
  assign bypass_hit = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (instr_valid) begin
          accept = 1'b1;
          if (!legal_in)       state_next = S_DONE;
          else if (bypass_hit) state_next = S_EXEC;
          else                 state_next = S_READ;
        end
      end
      S_READ:  state_next = S_WAIT;
      S_WAIT:  state_next = S_EXEC;
      S_EXEC:  state_next = S_WB;
      S_WB:    state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: synchronous active-low reset, sampled only on the clock edge.
  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  assign imm_sext = {{(DATA_W-16){imm_q[15]}}, imm_q};
  assign imm_zext = {{(DATA_W-16){1'b0}}, imm_q};

  always_comb begin
    alu_out = result;
    case (opcode_q)
      OP_ADDI: alu_out = op_a + imm_sext;
      OP_SUBI: alu_out = op_a - imm_sext;
      OP_ANDI: alu_out = op_a & imm_zext;
      OP_ORI:  alu_out = op_a | imm_zext;
      default: alu_out = result;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      opcode_q  <= '0;
      rt_q      <= '0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
      op_a      <= '0;
      rf_addr   <= '0;
      rf_we     <= 1'b0;
      rf_wdata  <= '0;
      result    <= '0;
    end else begin
      rf_we <= (state_next == S_WB);
      if (accept) begin
        opcode_q  <= instr[31:26];
        rt_q      <= ADDR_W'(instr[20:16]);
        imm_q     <= instr[15:0];
        illegal_q <= !legal_in;
      end
      if (state_next == S_READ) rf_addr <= rs_in;
      if (state == S_WAIT) op_a <= rf_rdata;
`ifdef IFMT_BYPASS_EN
      if (accept && legal_in && bypass_hit) op_a <= last_val;
`endif
      if (state == S_EXEC) begin
        result   <= alu_out;
        rf_wdata <= alu_out;
        rf_addr  <= rt_q;
      end
    end
  end

  assign instr_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign illegal     = done && illegal_q;

endmodule

// File: tb/tb_iformat_seq_ctrl.sv
// Self-checking bench for iformat_seq_ctrl: transaction-level model plus a
// registered-read register file, directed cases followed by random traffic.
module tb_iformat_seq_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
`ifdef IFMT_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clock       = 1'b0;
  logic        reset       = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr       = '0;
  logic [31:0] rf_rdata    = '0;
  logic        instr_ready;
  logic [4:0]  rf_addr;
  logic        rf_we;
  logic [31:0] rf_wdata;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        illegal;

  iformat_seq_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .rf_addr    (rf_addr),
    .rf_we      (rf_we),
    .rf_wdata   (rf_wdata),
    .rf_rdata   (rf_rdata),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .illegal    (illegal)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [31:0] mem  [32];
  logic [31:0] m_rf [32];

  // Model of the single transaction in flight
  bit          pend = 1'b0;
  int          acc  = 0;
  int          lat  = 0;
  bit          t_legal = 1'b0;
  logic [4:0]  t_rs = '0;
  logic [4:0]  t_rt = '0;
  logic [31:0] t_res = '0;
  logic [31:0] exp_result = '0;
  logic [31:0] exp_wdata  = '0;
  logic [4:0]  exp_addr   = '0;
  logic [4:0]  m_last_rt  = '0;
  bit          m_last_ok  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got 0x%08h, want 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s @cycle %0d: bound expired", name, cyc);
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'b001110, 6'b001111, 6'b011100, 6'b011000};
  endfunction

  function automatic logic [31:0] ref_op(input logic [5:0] op, input logic [31:0] a,
                                         input logic [15:0] imm);
    int signed s;
    s = int'($signed(imm));
    case (op)
      6'b001110: return a + 32'(s);
      6'b001111: return a - 32'(s);
      6'b011100: return a & {16'h0000, imm};
      6'b011000: return a | {16'h0000, imm};
      default:   return a;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    case ($urandom_range(0, 4))
      0:       op = 6'b001110;
      1:       op = 6'b001111;
      2:       op = 6'b011100;
      3:       op = 6'b011000;
      default: op = 6'($urandom);
    endcase
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
  endfunction

  // Bench register file: registered read, write not committed on a reset edge
  initial forever begin
    @(posedge clock);
    if (reset && rf_we) mem[rf_addr] = rf_wdata;
    if (!rf_we) rf_rdata <= mem[rf_addr];
  end

  // Transaction model, advanced on every rising edge
  initial forever begin
    bit was;
    bit byp;
    @(posedge clock);
    cyc++;
    if (!reset) begin
      pend       = 1'b0;
      exp_result = '0;
      exp_wdata  = '0;
      exp_addr   = '0;
      m_last_ok  = 1'b0;
    end else begin
      was = pend;
      if (was) begin
        if (t_legal && cyc == acc + lat - 2) begin
          exp_result = t_res;
          exp_wdata  = t_res;
          exp_addr   = t_rt;
        end
        if (t_legal && cyc == acc + lat - 1) begin
          m_rf[t_rt] = t_res;
          m_last_rt  = t_rt;
          m_last_ok  = 1'b1;
        end
        if (cyc == acc + lat) pend = 1'b0;
      end else if (instr_valid) begin
        pend    = 1'b1;
        acc     = cyc;
        t_legal = is_legal(instr[31:26]);
        t_rs    = instr[25:21];
        t_rt    = instr[20:16];
        byp     = BYPASS && t_legal && m_last_ok && (m_last_rt == t_rs);
        lat     = !t_legal ? 1 : (byp ? 3 : 5);
        t_res   = ref_op(instr[31:26], m_rf[t_rs], instr[15:0]);
        if (t_legal && !byp) exp_addr = t_rs;
      end
    end
  end

  // Compare process on the falling edge
  initial forever begin
    bit exp_done;
    bit exp_we;
    @(negedge clock);
    if (cyc > 0) begin
      exp_done = pend && (cyc == acc + lat - 1);
      exp_we   = pend && t_legal && (cyc == acc + lat - 2);
      check("instr_ready", instr_ready, !pend);
      check("busy", busy, pend);
      check("done", done, exp_done);
      check("illegal", illegal, exp_done && !t_legal);
      check("rf_we", rf_we, exp_we);
      check("rf_addr", rf_addr, exp_addr);
      check("rf_wdata", rf_wdata, exp_wdata);
      if (!pend || exp_done) check("result", result, exp_result);
    end
  end

  task automatic preload(input int idx, input logic [31:0] val);
    mem[idx]  = val;
    m_rf[idx] = val;
  endtask

  task automatic issue(input logic [31:0] word, output int acc_at);
    int guard = 0;
    while (!instr_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (!instr_ready) timeout("issue_ready");
    instr       = word;
    instr_valid = 1'b1;
    @(negedge clock);
    acc_at      = cyc;
    instr_valid = 1'b0;
    instr       = $urandom;
  endtask

  task automatic wait_done(input string name, input int acc_at, input int exp_lat,
                           output int we_cnt);
    bit seen = 1'b0;
    int k = 0;
    we_cnt = 0;
    while (!seen && k < 12) begin
      if (rf_we) we_cnt++;
      if (done) begin
        seen = 1'b1;
        check(name, cyc - acc_at + 1, exp_lat);
      end else begin
        @(negedge clock);
        k++;
      end
    end
    if (!seen) timeout(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog @cycle %0d: simulation did not finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a;
    int we_cnt;
    int dcnt;
    int guard;
    for (int i = 0; i < 32; i++) preload(i, 32'h0101_0101 * 32'(i));
    preload(11, 32'd212);
    preload(1, 32'd10);

    repeat (2) @(negedge clock);
    check("reset_ready", instr_ready, 1'b1);
    reset = 1'b1;

    // ADDI r14 = r11 + 15
    issue(32'h396E000F, a);
    wait_done("lat_addi", a, 5, we_cnt);
    check("addi_we_pulses", we_cnt, 1);
    check("addi_result", result, 32'd227);
    check("addi_r14", mem[14], 32'd227);
    check("model_r14", m_rf[14], 32'd227);

    // SUBI r4 = r1 - 5
    issue(32'h3C240005, a);
    wait_done("lat_subi", a, 5, we_cnt);
    check("subi_r4", mem[4], 32'd5);

    // ADDI r12 = r11 + sext(0xFFFF)
    issue(32'h396CFFFF, a);
    wait_done("lat_addi_neg", a, 5, we_cnt);
    check("addi_sext_r12", mem[12], 32'd211);
    check("addi_sext_result", result, 32'd211);

    // ANDI r13 = r11 & 0x00F0
    preload(11, 32'h0000_FFFF);
    issue(32'h716D00F0, a);
    wait_done("lat_andi", a, 5, we_cnt);
    check("andi_r13", mem[13], 32'h0000_00F0);

    // ORI r2 = r1 | zext(0x8001)
    preload(1, 32'hA000_0000);
    issue(32'h60228001, a);
    wait_done("lat_ori", a, 5, we_cnt);
    check("ori_zext_r2", mem[2], 32'hA000_8001);

    // Unsupported opcode
    issue(32'hFC000000, a);
    wait_done("lat_illegal", a, 1, we_cnt);
    check("illegal_flag", illegal, 1'b1);
    check("illegal_we_pulses", we_cnt, 0);
    check("illegal_result_held", result, 32'hA000_8001);

    // Reset lands in WB: write lost, no done
    preload(20, 32'h0000_0055);
    preload(11, 32'd212);
    issue(32'h39740001, a);
    guard = 0;
    while (!rf_we && guard < 10) begin
      @(negedge clock);
      guard++;
    end
    if (!rf_we) timeout("wb_reach");
    reset = 1'b0;
    @(negedge clock);
    check("wb_reset_we", rf_we, 1'b0);
    check("wb_reset_done", done, 1'b0);
    check("wb_reset_ready", instr_ready, 1'b1);
    reset = 1'b1;
    dcnt = 0;
    repeat (8) begin
      @(negedge clock);
      if (done) dcnt++;
    end
    check("wb_reset_no_done", dcnt, 0);
    check("wb_reset_r20", mem[20], 32'h0000_0055);

    // Dependent pair: r14 = r11 + 15, then r15 = r14 + 1
    issue(32'h396E000F, a);
    wait_done("lat_chain1", a, 5, we_cnt);
    issue(32'h39CF0001, a);
    wait_done("lat_chain2", a, BYPASS ? 3 : 5, we_cnt);
    check("chain_r15", mem[15], 32'd228);

    // Random traffic with occasional resets and valid held while busy
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      reset       = ($urandom_range(0, 249) != 0);
      instr_valid = ($urandom_range(0, 2) != 0);
      instr       = rand_instr();
    end
    @(negedge clock);
    reset       = 1'b1;
    instr_valid = 1'b0;
    repeat (8) @(negedge clock);
    for (int i = 0; i < 32; i++) check($sformatf("final_r%0d", i), mem[i], m_rf[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
